// File: rtl/layer_4_conv_sequencer_pkg.sv
// Shared definitions for the layer-4 convolution frame sequencer.
//   seq_state_e : frame sequencer FSM states
//   CNT_W       : row/column counter width for the default 104x104 padded frame
//   is_pad()    : true when (r, c) lies on the border of a p x p padded grid
// Optional feature macro: LAYER4_ZERO_PAD_EN (zero padding around the frame).
package layer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

    localparam int unsigned IMG_SIZE_DEF = 104;
    localparam int unsigned CNT_W        = $clog2(IMG_SIZE_DEF + 2);

    function automatic logic is_pad(input int unsigned r,
                                    input int unsigned c,
                                    input int unsigned p);
        return (r == 0) || (c == 0) || (r == p - 1) || (c == p - 1);
    endfunction

endpackage

// File: rtl/layer_4_conv_sequencer_if.sv
// Pixel stream bundle between upstream source, sequencer and conv bank.
//   in_data/in_valid/in_ready : upstream ready/valid pixel stream
//   conv_data/conv_valid      : padded pixel beat to the bank (data_in/valid_in)
//   win_valid                 : bank output this cycle is a full 3x3 window
// Modports: master = upstream/bank side, slave = sequencer.
interface layer_4_conv_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 1024
) ();
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] conv_data;
    logic                  conv_valid;
    logic                  win_valid;

    modport master (
        output in_data, in_valid,
        input  in_ready, conv_data, conv_valid, win_valid
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, conv_data, conv_valid, win_valid
    );
endinterface

// File: rtl/layer_4_conv_sequencer_valid_delay_line.sv
// 1-bit shift register aligning window tags with the conv bank's output.
//   clk, rst : clock, asynchronous active-high reset (clears the line)
//   din      : tag entering this cycle (0 for bubbles and non-window beats)
//   dout     : tag that entered DEPTH cycles ago
module valid_delay_line #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d    = '0;
        sr_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/layer_4_conv_sequencer.sv
// Frame sequencer for the layer-4 bank of 32 Conv2D3x3 channel engines.
// Walks a padded raster grid, inserting zero pad beats around the frame,
// forwards upstream pixels at interior positions, and tags bank outputs
// that are complete 3x3 window results.
//   Clk, Rst   : clock, asynchronous active-high reset (aborts a frame)
//   start      : one-cycle pulse, starts a frame while IDLE
//   bus        : slave side of layer_4_conv_sequencer_if (stream in, bank out)
//   busy       : frame in progress (STREAM or FLUSH)
//   done       : one-cycle pulse once the frame has drained through the bank
// Macro LAYER4_ZERO_PAD_EN: defined -> padded (same-size) output;
//                           undefined -> no padding (valid-size) output.
module layer_4_conv_sequencer
    import layer_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned IMG_SIZE   = 104,
    parameter int unsigned CONV_LAT   = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    layer_4_conv_sequencer_if.slave  bus,
    output logic                     busy,
    output logic                     done
);
`ifdef LAYER4_ZERO_PAD_EN
    localparam bit          PAD_EN = 1'b1;
    localparam int unsigned P      = IMG_SIZE + 2;
`else
    localparam bit          PAD_EN = 1'b0;
    localparam int unsigned P      = IMG_SIZE;
`endif
    localparam int unsigned CW = $clog2(P);
    localparam int unsigned FW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    seq_state_e            state_q, state_d;
    logic [CW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic [FW-1:0]         flush_q, flush_d;
    logic [DATA_WIDTH-1:0] conv_data_q, conv_data_d;
    logic                  conv_valid_q, conv_valid_d;
    logic                  tag_q, tag_d;

    logic pad;
    logic in_ready;
    logic beat;

    always_comb begin
        pad      = PAD_EN && is_pad(32'(r_q), 32'(c_q), P);
        in_ready = (state_q == STREAM) && !pad;
        // A beat is issued on every pad position, or on an interior transfer;
        // anything else is a bubble and leaves the counters where they are.
        beat     = (state_q == STREAM) && (pad || (in_ready && bus.in_valid));

        state_d      = state_q;
        r_d          = r_q;
        c_d          = c_q;
        flush_d      = flush_q;
        conv_data_d  = conv_data_q;
        conv_valid_d = 1'b0;
        tag_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = STREAM;
            end
            STREAM: begin
                if (beat) begin
                    conv_valid_d = 1'b1;
                    conv_data_d  = pad ? '0 : bus.in_data;
                    tag_d        = (32'(r_q) >= 32'd2) && (32'(c_q) >= 32'd2);
                    if (c_q == LAST) begin
                        c_d = '0;
                        r_d = (r_q == LAST) ? '0 : r_q + CW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                    if (r_q == LAST && c_q == LAST) begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end
                end
            end
            FLUSH: begin
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(CONV_LAT - 1)) begin
                    state_d = DONE;
                    flush_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            r_q          <= '0;
            c_q          <= '0;
            flush_q      <= '0;
            conv_data_q  <= '0;
            conv_valid_q <= 1'b0;
            tag_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            flush_q      <= flush_d;
            conv_data_q  <= conv_data_d;
            conv_valid_q <= conv_valid_d;
            tag_q        <= tag_d;
        end
    end

    // tag_q is aligned with conv_valid, so the delay line output lines up
    // with the bank's data_out for the same beat.
    valid_delay_line #(
        .DEPTH(CONV_LAT)
    ) u_valid_delay_line (
        .clk  (Clk),
        .rst  (Rst),
        .din  (tag_q),
        .dout (bus.win_valid)
    );

    assign bus.in_ready   = in_ready;
    assign bus.conv_data  = conv_data_q;
    assign bus.conv_valid = conv_valid_q;
    assign busy           = (state_q == STREAM) || (state_q == FLUSH);
    assign done           = (state_q == DONE);
endmodule
